ram_sync_param: RTL and testbench

Parametrised single-port synchronous RAM: the next generation of the team's 16x2 storage block for the audio-logic simulator. Width and depth are parameters. Reads are registered, with a read-valid strobe. A built-in clear sequencer sweeps every word to a programmable value after reset or on request. It sits beside the sequencer and sample-buffer logic as general-purpose storage, and keeps the tri-state read bus used on the shared data lines.

---
 rtl/ram_sync_param.sv | 110 +++++++++++
 tb/tb_ram_sync_param.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with registered reads, a read-valid strobe and a clear-sweep sequencer.
// Optional macro RAM_SYNC_BYPASS_EN: write-first on same-address read/write (default build is read-first).
module ram_sync_param #(
  parameter int                    DATA_WIDTH = 2,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  oe,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output tri   [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  busy
);

  // state    | meaning
  // ST_SWEEP | writing INIT_VALUE to mem[ptr], one word per edge; busy=1
  // ST_READY | normal read/write service; busy=0

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {ST_SWEEP, ST_READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH:0]     ptr;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    host_wr;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   rd_data;

  // clr in READY wins over any host access in the same cycle
  assign host_wr = (state == ST_READY) && !clr && we;

`ifdef RAM_SYNC_BYPASS_EN
  assign rd_data = we ? data_in : mem[addr];
`else
  assign rd_data = mem[addr];
`endif

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data_in;
    if (!rst) begin
      if (state == ST_SWEEP) begin
        mem_we    = 1'b1;
        mem_waddr = ptr[ADDR_WIDTH-1:0];
        mem_wdata = INIT_VALUE;
      end else if (host_wr) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_SWEEP;
      ptr      <= '0;
      busy     <= 1'b1;
      rd_q     <= INIT_VALUE;
      rd_valid <= 1'b0;
    end else begin
      case (state)
        ST_SWEEP: begin
          rd_valid <= 1'b0;
          if (ptr == PTR_LAST) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ST_READY: begin
          if (clr) begin
            state    <= ST_SWEEP;
            ptr      <= '0;
            busy     <= 1'b1;
            rd_q     <= INIT_VALUE;
            rd_valid <= 1'b0;
          end else begin
            rd_valid <= oe;
            if (oe) rd_q <= rd_data;
          end
        end
        default: begin
          state <= ST_SWEEP;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Shared data lines: only drive while a read is requested and no sweep is running
  assign data_out = (oe && !busy) ? rd_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_sync_param.sv
// Directed self-checking bench for ram_sync_param: default instance plus an 8x64 instance with INIT_VALUE=8'hA5.
// Bus lines are pulled up, so a released (high-Z) bus reads as all ones.
`timescale 1ns/1ps
module tb_ram_sync_param;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, we, oe, clr;
  logic [3:0] addr;
  logic [1:0] data_in;
  tri1  [1:0] data_out;
  logic       rd_valid, busy;

  logic       rst1, we1, oe1, clr1;
  logic [5:0] addr1;
  logic [7:0] data_in1;
  tri1  [7:0] data_out1;
  logic       rd_valid1, busy1;

  int errors = 0;
  int checks = 0;

  ram_sync_param dut (
    .clk(clk), .rst(rst), .we(we), .oe(oe), .clr(clr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid), .busy(busy)
  );

  ram_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .INIT_VALUE(8'hA5)) dut_wide (
    .clk(clk), .rst(rst1), .we(we1), .oe(oe1), .clr(clr1), .addr(addr1),
    .data_in(data_in1), .data_out(data_out1), .rd_valid(rd_valid1), .busy(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; oe = 1'b1;
    step(); step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (data_out !== 2'b11) begin errors++; $display("FAIL reset_bus_z: got %b expected released(11)", data_out); end
    rst = 1'b0; oe = 1'b0;
    n = 0;
    do begin
      step(); n++;
      if (n == 8) begin
        oe = 1'b1; #1;
        checks++; if (data_out !== 2'b11) begin errors++; $display("FAIL sweep_bus_z: got %b expected released(11)", data_out); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL sweep_rd_valid: got %b expected 0", rd_valid); end
        oe = 1'b0;
      end
    end while (busy && n < 200);
    checks++; if (n != 16) begin errors++; $display("FAIL reset_sweep_len: got %0d edges expected 16", n); end
    oe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      step();
      checks++; if (rd_valid !== 1'b1 || data_out !== 2'b00)
        begin errors++; $display("FAIL reset_read_%0d: got v=%b d=%b expected v=1 d=00", i, rd_valid, data_out); end
    end
    oe = 1'b0;
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_drop: got %b expected 0", rd_valid); end
  endtask

  task automatic test_write_read();
    we = 1'b1; addr = 4'd5; data_in = 2'b10;
    step();
    we = 1'b0; oe = 1'b1; data_in = 2'b00;
    step();
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_valid: got %b expected 1", rd_valid); end
    checks++; if (data_out !== 2'b10) begin errors++; $display("FAIL wr_rd_data: got %b expected 10", data_out); end
    oe = 1'b0; #1;
    checks++; if (data_out !== 2'b11) begin errors++; $display("FAIL wr_rd_oe_low_z: got %b expected released(11)", data_out); end
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_pulse: got %b expected 0", rd_valid); end
    // rd_q holds: re-enabling the bus without a new edge shows the old read
    oe = 1'b1; #1;
    checks++; if (data_out !== 2'b10) begin errors++; $display("FAIL wr_rd_hold: got %b expected 10", data_out); end
    oe = 1'b0;
  endtask

  task automatic test_collision();
    logic [1:0] exp_first;
`ifdef RAM_SYNC_BYPASS_EN
    exp_first = 2'b11;
`else
    exp_first = 2'b01;
`endif
    we = 1'b1; addr = 4'd3; data_in = 2'b01;
    step();
    we = 1'b1; oe = 1'b1; data_in = 2'b11;
    step();
    checks++; if (data_out !== exp_first) begin errors++; $display("FAIL collide_read: got %b expected %b", data_out, exp_first); end
    we = 1'b0;
    step();
    checks++; if (data_out !== 2'b11 || rd_valid !== 1'b1)
      begin errors++; $display("FAIL collide_followup: got v=%b d=%b expected v=1 d=11", rd_valid, data_out); end
    oe = 1'b0;
  endtask

  task automatic test_clear();
    int n;
    we = 1'b1; data_in = 2'b11;
    for (int i = 0; i < 16; i++) begin addr = 4'(i); step(); end
    we = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy: got %b expected 1", busy); end
    n = 0;
    do begin
      if (n == 3) begin we = 1'b1; oe = 1'b1; addr = 4'd0; data_in = 2'b11; end
      else begin we = 1'b0; oe = 1'b0; end
      step(); n++;
      if (n == 4) begin
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL clr_oe_ignored: got %b expected 0", rd_valid); end
      end
    end while (busy && n < 200);
    we = 1'b0; oe = 1'b0;
    checks++; if (n != 16) begin errors++; $display("FAIL clr_sweep_len: got %0d edges expected 16", n); end
    oe = 1'b1; #1;
    checks++; if (data_out !== 2'b00) begin errors++; $display("FAIL clr_rd_q_init: got %b expected 00", data_out); end
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      step();
      checks++; if (data_out !== 2'b00) begin errors++; $display("FAIL clr_read_%0d: got %b expected 00", i, data_out); end
    end
    oe = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy: got %b expected 1", busy); end
    n = 0;
    do begin step(); n++; end while (busy && n < 200);
    checks++; if (n != 16) begin errors++; $display("FAIL mid_rst_sweep_len: got %0d edges expected 16", n); end
  endtask

  task automatic test_wide_params();
    int n;
    rst1 = 1'b1; oe1 = 1'b1;
    step(); step();
    rst1 = 1'b0;
    n = 0;
    do begin
      step(); n++;
      if (n == 30) begin
        checks++; if (data_out1 !== 8'hFF) begin errors++; $display("FAIL wide_sweep_bus_z: got %h expected released(ff)", data_out1); end
      end
    end while (busy1 && n < 300);
    oe1 = 1'b0;
    checks++; if (n != 64) begin errors++; $display("FAIL wide_sweep_len: got %0d edges expected 64", n); end
    we1 = 1'b1; addr1 = 6'd63; data_in1 = 8'h3C;
    step();
    we1 = 1'b0; oe1 = 1'b1; addr1 = 6'd0;
    step();
    checks++; if (data_out1 !== 8'hA5 || rd_valid1 !== 1'b1)
      begin errors++; $display("FAIL wide_read_0: got v=%b d=%h expected v=1 d=a5", rd_valid1, data_out1); end
    addr1 = 6'd63;
    step();
    checks++; if (data_out1 !== 8'h3C) begin errors++; $display("FAIL wide_read_63: got %h expected 3c", data_out1); end
    addr1 = 6'd62;
    step();
    checks++; if (data_out1 !== 8'hA5) begin errors++; $display("FAIL wide_read_62: got %h expected a5", data_out1); end
    oe1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; oe = 1'b0; clr = 1'b0; addr = '0; data_in = '0;
    rst1 = 1'b1; we1 = 1'b0; oe1 = 1'b0; clr1 = 1'b0; addr1 = '0; data_in1 = '0;
    #2;
    test_reset();
    test_write_read();
    test_collision();
    test_clear();
    test_reset_mid_sweep();
    test_wide_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
